// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/done handshake bundle for bin_to_bcd_seq
//
// Purpose: groups the conversion request and the result signals of the
//   sequential binary-to-BCD converter.
// Signals:
//   start     requester -> converter  conversion request (taken only when idle)
//   bin       requester -> converter  binary operand, BIN_W bits
//   busy      converter -> requester  conversion in progress
//   done      converter -> requester  one-cycle pulse, bcd/overflow updated
//   bcd       converter -> requester  packed BCD, digit 0 in bits [3:0]
//   overflow  converter -> requester  value needed more than DIGITS digits
//   sign      converter -> requester  operand was negative (BIN_TO_BCD_SIGNED_EN only)
// Modports: master (requester side), slave (converter side).
// Build option: BIN_TO_BCD_SIGNED_EN adds the sign signal.

interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BIN_TO_BCD_SIGNED_EN
  logic                  sign;

  modport master (output start, output bin,
                  input busy, input done, input bcd, input overflow, input sign);
  modport slave  (input start, input bin,
                  output busy, output done, output bcd, output overflow, output sign);
`else
  modport master (output start, output bin,
                  input busy, input done, input bcd, input overflow);
  modport slave  (input start, input bin,
                  output busy, output done, output bcd, output overflow);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter
//
// Purpose: converts a BIN_W-bit binary operand into DIGITS packed BCD digits,
//   one operand bit per clock (shift-add-3), with a start/done handshake.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bin_to_bcd_seq_if.slave: start/bin in, busy/done/bcd/overflow out
// Timing: start accepted at edge N -> done high in the cycle after edge
//   N+BIN_W+1; busy high from edge N until that same edge.
// Build option: BIN_TO_BCD_SIGNED_EN treats bin as two's complement and
//   reports the sign on bus.sign; the magnitude is converted.

module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [BIN_W-1:0]   shreg_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               sticky_q;

  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic               accept;
  logic [BIN_W-1:0]   load_val;

  assign accept = (state_q == IDLE) && bus.start;

`ifdef BIN_TO_BCD_SIGNED_EN
  // Negate in BIN_W+1 bits so the most negative operand yields its true
  // magnitude 2**(BIN_W-1), which still fits in BIN_W unsigned bits.
  logic [BIN_W:0]     bin_ext;
  logic [BIN_W:0]     bin_neg;
  logic               neg_in;
  logic               sign_work_q;
  logic               sign_q;

  assign neg_in   = bus.bin[BIN_W-1];
  assign bin_ext  = {neg_in, bus.bin};
  assign bin_neg  = -bin_ext;
  assign load_val = neg_in ? bin_neg[BIN_W-1:0] : bus.bin;
  assign bus.sign = sign_q;
`else
  assign load_val = bus.bin;
`endif

  // Add 3 to every digit >= 5 so that the following left shift carries
  // correctly into the next decade; all digits adjust in parallel.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
      sign_work_q <= 1'b0;
      sign_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q     <= load_val;
            scratch_q   <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= CNT_W'(BIN_W);
            busy_q      <= 1'b1;
`ifdef BIN_TO_BCD_SIGNED_EN
            sign_work_q <= neg_in;
`endif
          end
        end
        SHIFT: begin
          scratch_q <= {scratch_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
          shreg_q   <= shreg_q << 1;
          // A one leaving the top digit means the value needs another digit.
          if (scratch_adj[BCD_W-1]) begin
            sticky_q <= 1'b1;
          end
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FINISH: begin
          bcd_q  <= scratch_q;
          ovf_q  <= sticky_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
          sign_q <= sign_work_q;
`endif
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
//
// Purpose: drives a 32-bit/10-digit and a 10-bit/2-digit converter with
//   directed vectors and checks latency, busy, result, overflow and reset.
// Ports: none (top-level bench). Honours BIN_TO_BCD_SIGNED_EN.

module tb_bin_to_bcd_seq;

`ifdef BIN_TO_BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(32), .DIGITS(10)) bus_a ();
  bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(2))  bus_b ();

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit digits_ok(input logic [39:0] b, input int n);
    for (int i = 0; i < 10; i++) begin
      if (i < n && b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Convert v on the 32-bit instance; spur1/spur2 are cycles (1-based after
  // the accepting edge) where a stray start is driven, 0 for none.
  task automatic run_a(input string tag, input logic [31:0] v, input logic [39:0] exp_bcd,
                       input logic exp_ovf, input int spur1, input int spur2);
    int k;
    int busy_cnt;
    bit seen;
    bus_a.bin   = v;
    bus_a.start = 1'b1;
    next_cycle;
    bus_a.start = 1'b0;
    bus_a.bin   = $urandom;
    k = 1;
    busy_cnt = 0;
    seen = 1'b0;
    while (k <= 60 && !seen) begin
      if (bus_a.done) begin
        seen = 1'b1;
      end else begin
        if (bus_a.busy) busy_cnt++;
        bus_a.start = (k == spur1 || k == spur2);
        bus_a.bin   = $urandom;
        next_cycle;
        k++;
      end
    end
    bus_a.start = 1'b0;
    check({tag, " latency"}, 64'(k), 64'd34);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " busy_at_done"}, 64'(bus_a.busy), 64'd0);
    check({tag, " bcd"}, 64'(bus_a.bcd), 64'(exp_bcd));
    check({tag, " overflow"}, 64'(bus_a.overflow), 64'(exp_ovf));
    check({tag, " digits"}, 64'(digits_ok(bus_a.bcd, 10)), 64'd1);
`ifdef BIN_TO_BCD_SIGNED_EN
    check({tag, " sign"}, 64'(bus_a.sign), 64'(v[31]));
`endif
  endtask

  task automatic run_b(input string tag, input logic [9:0] v, input logic [7:0] exp_bcd,
                       input logic exp_ovf);
    int k;
    int busy_cnt;
    bit seen;
    bus_b.bin   = v;
    bus_b.start = 1'b1;
    next_cycle;
    bus_b.start = 1'b0;
    bus_b.bin   = 10'($urandom);
    k = 1;
    busy_cnt = 0;
    seen = 1'b0;
    while (k <= 30 && !seen) begin
      if (bus_b.done) begin
        seen = 1'b1;
      end else begin
        if (bus_b.busy) busy_cnt++;
        next_cycle;
        k++;
      end
    end
    check({tag, " latency"}, 64'(k), 64'd12);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd11);
    check({tag, " bcd"}, 64'(bus_b.bcd), 64'(exp_bcd));
    check({tag, " overflow"}, 64'(bus_b.overflow), 64'(exp_ovf));
    check({tag, " digits"}, 64'(digits_ok(40'(bus_b.bcd), 2)), 64'd1);
`ifdef BIN_TO_BCD_SIGNED_EN
    check({tag, " sign"}, 64'(bus_b.sign), 64'(v[9]));
`endif
  endtask

  initial begin
    int done_cnt;
    bus_a.start = 1'b0;
    bus_a.bin   = '0;
    bus_b.start = 1'b0;
    bus_b.bin   = '0;
    rst_n = 1'b0;
    repeat (3) next_cycle;

    check("rst busy_a", 64'(bus_a.busy), 64'd0);
    check("rst done_a", 64'(bus_a.done), 64'd0);
    check("rst bcd_a", 64'(bus_a.bcd), 64'd0);
    check("rst ovf_a", 64'(bus_a.overflow), 64'd0);
    check("rst busy_b", 64'(bus_b.busy), 64'd0);
    check("rst bcd_b", 64'(bus_b.bcd), 64'd0);
    rst_n = 1'b1;
    next_cycle;

    run_a("zero", 32'd0, 40'h0, 1'b0, 0, 0);
    run_a("max", 32'hFFFF_FFFF, SGN ? 40'h1 : 40'h42_9496_7295, 1'b0, 0, 0);
    run_a("12345", 32'd12345, 40'h12345, 1'b0, 0, 0);

    // Stray starts mid-conversion are ignored; done is a single pulse.
    run_a("678", 32'd678, 40'h678, 1'b0, 5, 20);
    next_cycle;
    check("678 done_pulse", 64'(bus_a.done), 64'd0);
    check("678 bcd_hold", 64'(bus_a.bcd), 64'h678);
    run_a("b2b", 32'd9876, 40'h9876, 1'b0, 0, 0);

    // Reset in cycle 10 of a conversion, released at cycle 12.
    bus_a.bin   = 32'd555;
    bus_a.start = 1'b1;
    next_cycle;
    bus_a.start = 1'b0;
    repeat (9) next_cycle;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(bus_a.busy), 64'd0);
    check("midrst bcd", 64'(bus_a.bcd), 64'd0);
    next_cycle;
    next_cycle;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle;
      if (bus_a.done) done_cnt++;
    end
    check("midrst no_done", 64'(done_cnt), 64'd0);
    check("midrst busy_after", 64'(bus_a.busy), 64'd0);
    check("midrst bcd_after", 64'(bus_a.bcd), 64'd0);
    run_a("42", 32'd42, 40'h42, 1'b0, 0, 0);

    run_b("s999", 10'd999, SGN ? 8'h25 : 8'h99, SGN ? 1'b0 : 1'b1);
    run_b("s99", 10'd99, 8'h99, 1'b0);
    run_b("s1023", 10'd1023, SGN ? 8'h01 : 8'h23, SGN ? 1'b0 : 1'b1);
    run_b("s100", 10'd100, 8'h00, 1'b1);

`ifdef BIN_TO_BCD_SIGNED_EN
    run_a("neg123", 32'hFFFF_FF85, 40'h123, 1'b0, 0, 0);
    run_a("minneg", 32'h8000_0000, 40'h21_4748_3648, 1'b0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
